// File: rtl/addr_stream_sink.sv
// rtl/addr_stream_sink.sv - address/valid stream sink: issues memory reads, sums returned data, checks ordering
module addr_stream_sink #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_ADDR   = 100,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  valid_i,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  done_o,
    output logic                  busy_o,
    output logic [ACC_WIDTH-1:0]  sum_o,
    output logic                  sum_valid_o,
    output logic                  err_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ADDR - 1);
    localparam logic [ACC_WIDTH-1:0]  SUM_MAX   = '1;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic                  rd_pend;
    logic                  accept;
    logic [ACC_WIDTH:0]    sum_ext;

    // Only RUN consumes the stream; over-run addresses after the last one land in DRAIN/DONE/IDLE.
    assign accept      = (state == S_RUN) && valid_i;
    assign mem_rd_en_o = accept;
    assign mem_addr_o  = addr_i;
    assign done_o      = (state == S_DONE);
    assign busy_o      = (state == S_RUN) || (state == S_DRAIN);

    // One extra carry bit detects overflow so the sum saturates instead of wrapping.
    assign sum_ext = {1'b0, sum_o} + (ACC_WIDTH+1)'(mem_rdata_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            exp_addr    <= '0;
            rd_pend     <= 1'b0;
            sum_o       <= '0;
            sum_valid_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            rd_pend <= accept;
            if (rd_pend) begin
                sum_o <= sum_ext[ACC_WIDTH] ? SUM_MAX : sum_ext[ACC_WIDTH-1:0];
            end
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state       <= S_RUN;
                        sum_o       <= '0;
                        err_o       <= 1'b0;
                        sum_valid_o <= 1'b0;
                        exp_addr    <= '0;
                        rd_pend     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (valid_i) begin
                        if (addr_i != exp_addr) begin
                            err_o <= 1'b1;
                        end
                        exp_addr <= exp_addr + 1'b1;
                        if (exp_addr == LAST_ADDR) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    sum_valid_o <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_stream_sink.sv
// tb/tb_addr_stream_sink.sv - randomized self-checking bench for addr_stream_sink
module tb_addr_stream_sink;

    localparam int AW = 7;
    localparam int DW = 8;
    localparam int N  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, valid;
    logic [AW-1:0] addr;

    logic          rd_a, rd_b, rd_c;
    logic [AW-1:0] ma_a, ma_b, ma_c;
    logic [DW-1:0] rdat_a, rdat_b, rdat_c;
    logic          done_a, done_b, done_c;
    logic          busy_a, busy_b, busy_c;
    logic [15:0]   sum_a;
    logic [7:0]    sum_b;
    logic [15:0]   sum_c;
    logic          sv_a, sv_b, sv_c;
    logic          err_a, err_b, err_c;

    logic [DW-1:0] mem_a [0:127];

    int n_vec = 0;
    int n_err = 0;

    addr_stream_sink #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ADDR(N), .ACC_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .start_i(start), .addr_i(addr), .valid_i(valid),
        .mem_rd_en_o(rd_a), .mem_addr_o(ma_a), .mem_rdata_i(rdat_a),
        .done_o(done_a), .busy_o(busy_a), .sum_o(sum_a), .sum_valid_o(sv_a), .err_o(err_a));

    addr_stream_sink #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ADDR(N), .ACC_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .start_i(start), .addr_i(addr), .valid_i(valid),
        .mem_rd_en_o(rd_b), .mem_addr_o(ma_b), .mem_rdata_i(rdat_b),
        .done_o(done_b), .busy_o(busy_b), .sum_o(sum_b), .sum_valid_o(sv_b), .err_o(err_b));

    addr_stream_sink #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ADDR(1), .ACC_WIDTH(16)) dut_c (
        .clk(clk), .rst(rst), .start_i(start), .addr_i(addr), .valid_i(valid),
        .mem_rd_en_o(rd_c), .mem_addr_o(ma_c), .mem_rdata_i(rdat_c),
        .done_o(done_c), .busy_o(busy_c), .sum_o(sum_c), .sum_valid_o(sv_c), .err_o(err_c));

    // Synchronous memories, 1-cycle read latency; dut_b sees an all-0xFF memory.
    always @(posedge clk) begin
        if (rd_a) rdat_a <= mem_a[ma_a];
        if (rd_b) rdat_b <= 8'hFF;
        if (rd_c) rdat_c <= mem_a[ma_c];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full run: bad_at selects which accepted address is wrong (-1 none); max_bub bounds bubbles.
    task automatic do_run(input int bad_at, input int max_bub);
        int k, it, last_it, first_it, bub, tot_a, tot_b, tot_c, exp_a, exp_b;
        logic v, exp_rd, e_err, e_err_c;
        logic [AW-1:0] a;
        k = 0; it = 0; last_it = -1; first_it = -1;
        tot_a = 0; tot_b = 0; tot_c = 0; e_err = 1'b0; e_err_c = 1'b0;
        bub = $urandom_range(0, max_bub);

        @(negedge clk);
        start = 1'b1; valid = 1'b1; addr = AW'($urandom);
        #1;
        check("idle_rd_en", 32'(rd_a), 32'(0));
        check("idle_busy", 32'(busy_a), 32'(0));
        @(posedge clk);

        while (last_it < 0 || it <= last_it + 3) begin
            @(negedge clk);
            if (last_it < 0) begin
                if (bub > 0) begin
                    v = 1'b0; a = AW'($urandom); bub--;
                end else begin
                    v = 1'b1;
                    a = (k == bad_at) ? ((k == 0) ? AW'(5) : AW'(k - 1)) : AW'(k);
                    bub = $urandom_range(0, max_bub);
                end
            end else if (it <= last_it + 2) begin
                v = 1'b1; a = AW'(N + it - last_it - 1);
            end else begin
                v = 1'b0; a = AW'($urandom);
            end
            valid = v; addr = a;
            start = ((first_it < 0 || it <= first_it + 2) && (last_it < 0 || it <= last_it + 2))
                    ? ($urandom_range(0, 3) == 0) : 1'b0;
            #1;
            exp_rd = v && (last_it < 0);
            check("rd_en", 32'(rd_a), 32'(exp_rd));
            if (exp_rd) check("mem_addr", 32'(ma_a), 32'(a));
            check("done", 32'(done_a), 32'(last_it >= 0 && it == last_it + 2));
            check("done_b", 32'(done_b), 32'(last_it >= 0 && it == last_it + 2));
            check("done_c", 32'(done_c), 32'(first_it >= 0 && it == first_it + 2));
            check("busy", 32'(busy_a), 32'(last_it < 0 || it <= last_it + 1));
            check("err", 32'(err_a), 32'(e_err));
            check("sum_valid", 32'(sv_a), 32'(last_it >= 0 && it >= last_it + 3));
            if (exp_rd) begin
                tot_a += int'(mem_a[a]);
                tot_b += 255;
                if (a != AW'(k)) e_err = 1'b1;
                if (k == 0) begin
                    first_it = it;
                    tot_c    = int'(mem_a[a]);
                    e_err_c  = (a != AW'(0));
                end
                k++;
                if (k == N) last_it = it;
            end
            if (last_it >= 0 && it == last_it + 3) begin
                exp_a = (tot_a > 65535) ? 65535 : tot_a;
                exp_b = (tot_b > 255) ? 255 : tot_b;
                check("sum_a", 32'(sum_a), 32'(exp_a));
                check("sum_b_sat", 32'(sum_b), 32'(exp_b));
                check("err_b", 32'(err_b), 32'(e_err));
                check("sum_c", 32'(sum_c), 32'(tot_c));
                check("err_c", 32'(err_c), 32'(e_err_c));
                check("sv_c", 32'(sv_c), 32'(1));
            end
            @(posedge clk);
            it++;
        end
        start = 1'b0; valid = 1'b0;
    endtask

    task automatic do_reset_mid();
        @(negedge clk);
        start = 1'b1; valid = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b0; valid = 1'b1; addr = AW'(i);
            @(posedge clk);
        end
        @(negedge clk);
        valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy_a), 32'(0));
        check("rst_sum", 32'(sum_a), 32'(0));
        check("rst_err", 32'(err_a), 32'(0));
        check("rst_sv", 32'(sv_a), 32'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid = 1'b1; addr = AW'(2 + i);
            #1;
            check("rst_done", 32'(done_a), 32'(0));
            check("rst_rd_en", 32'(rd_a), 32'(0));
        end
        valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; addr = '0;
        for (int i = 0; i < 128; i++) mem_a[i] = DW'(i + 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_sum", 32'(sum_a), 32'(0));
        check("reset_sv", 32'(sv_a), 32'(0));
        check("reset_err", 32'(err_a), 32'(0));
        check("reset_done", 32'(done_a), 32'(0));
        check("reset_busy", 32'(busy_a), 32'(0));

        do_run(-1, 0);
        check("plain_sum_10", 32'(sum_a), 32'(10));
        do_run(-1, 2);
        do_run(2, 0);
        check("bad_err_sticky", 32'(err_a), 32'(1));
        do_reset_mid();
        do_run(-1, 1);

        for (int i = 0; i < 128; i++) mem_a[i] = DW'($urandom);
        for (int r = 0; r < 8; r++) begin
            int sel;
            sel = $urandom_range(0, 6);
            do_run((sel < N) ? sel : -1, 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
